regbank_master: RTL and testbench
=================================

// Module: regbank_master
// PURPOSE
//  Command-driven initiator for the 2-read/1-write register bank: owns its ra1/ra2/wa/write/wdata
//  pins and consumes rdata1/rdata2. Accepts WRITE/READ/SWAP/COPY commands on a valid/ready port,
//  sequences the single-write-port accesses and returns read data on a valid/ready response port.
// PARAMETERS
//  DW    32   data width, equal to the bank word width
//  AW    2    register address width; NREG = 2**AW (localparam, 4 at default)
// PORTS
//  clk        in   1   rising-edge clock, shared with the bank
//  rst_n      in   1   asynchronous, active-low reset
//  cmd_valid  in   1   command present
//  cmd_ready  out  1   block can accept a command
//  cmd_op     in   2   00 WRITE, 01 READ, 10 SWAP, 11 COPY
//  cmd_a      in   AW  first register / destination
//  cmd_b      in   AW  second register / source
//  cmd_data   in   DW  WRITE data
//  rsp_valid  out  1   READ result present
//  rsp_ready  in   1   response consumer ready
//  rsp_data1  out  DW  contents of reg[a]
//  rsp_data2  out  DW  contents of reg[b]
//  busy       out  1   high whenever state != IDLE
//  rb_ra1     out  AW  bank read address 1
//  rb_ra2     out  AW  bank read address 2
//  rb_wa      out  AW  bank write address
//  rb_write   out  1   bank write enable; bank commits rb_wdata to reg[rb_wa] at rising clk
//  rb_wdata   out  DW  bank write data
//  rb_rdata1  in   DW  bank read data 1, combinational from rb_ra1
//  rb_rdata2  in   DW  bank read data 2, combinational from rb_ra2
// BEHAVIOUR
//  - All outputs registered. Reset (async, rst_n=0): rb_write=0, rb_wa/rb_ra1/rb_ra2=0, rb_wdata=0,
//    rsp_valid=0, rsp_data1/2=0, temps=0; state=INIT if INIT_CLEAR_EN else IDLE.
//  - States: INIT, IDLE, RD, WR1, WR2, RESP. cmd_ready=1 only in IDLE; busy=!IDLE.
//  - Accept on cmd_valid&&cmd_ready at edge N; op/a/b/data latched; cmd_* ignored outside IDLE.
//  - WRITE: IDLE->WR1: rb_write=1, rb_wa=a, rb_wdata=data for one cycle -> IDLE. Commit edge N+1.
//  - READ: IDLE->RD: rb_ra1=a, rb_ra2=b; at end of RD capture rb_rdata1/2 into rsp_data1/2, ->RESP.
//    RESP: rsp_valid=1, data stable until rsp_valid&&rsp_ready edge -> IDLE, rsp_valid=0.
//  - SWAP: RD captures tmp1=reg[a], tmp2=reg[b]; WR1 writes reg[a]=tmp2; WR2 writes reg[b]=tmp1;
//    -> IDLE. 3 busy cycles. a==b: both writes occur, net contents unchanged.
//  - COPY (reg[a]=reg[b]): RD captures tmp2=reg[b]; WR1 writes reg[a]=tmp2; -> IDLE. a==b harmless.
//  - rb_write is 1 only in INIT, WR1, WR2; never two writes to the bank in one cycle by construction.
//  - No response for WRITE/SWAP/COPY; rsp_valid only for READ. Back-to-back commands: next accept
//    no earlier than the cycle after return to IDLE (cmd_ready rises the cycle after last write).
//  - Address arithmetic wraps mod NREG (INIT counter). All data paths full DW, no truncation.
//  - Reset mid-operation: immediate return to reset values; an in-flight SWAP may leave reg[a]
//    updated and reg[b] not; no write issued after rst_n falls.
// CONFIGURATION
//  REGBANK_INIT_CLEAR_EN defined: after reset release, INIT sweeps rb_wa=0..NREG-1 with rb_write=1,
//    rb_wdata=0, one register per cycle (NREG cycles), cmd_ready=0, busy=1, then IDLE.
//  Not defined: reset enters IDLE directly, cmd_ready=1 first cycle after release; bank untouched.
// TESTING
//  1. INIT_CLEAR_EN, release rst_n -> rb_write=1 for 4 cycles, rb_wa 0,1,2,3, rb_wdata 0; then cmd_ready=1.
//  2. WRITE a=1 32'h00145601; WRITE a=2 32'h00000987; READ a=2 b=1 -> rsp_data1=00000987, rsp_data2=00145601.
//  3. After 2: SWAP a=1 b=2, READ a=1 b=2 -> rsp_data1=00000987, rsp_data2=00145601; SWAP busy 3 cycles.
//  4. READ with rsp_ready=0 for 5 cycles -> rsp_valid held, data stable, cmd_ready=0, queued cmd not taken.
//  5. COPY a=3 b=1 then READ 3,1 -> both 00000987; SWAP a=b=2 then READ 2,2 -> both 00145601.
//  6. rst_n low during WR1 of a SWAP -> rb_write=0, rsp_valid=0, busy re-initialised same instant (async).

Source files
------------

// File: rtl/regbank_master.sv
// Command sequencer driving a 2-read/1-write register bank.
// Optional power-up clear sweep: define REGBANK_INIT_CLEAR_EN.
module regbank_master #(
    parameter int DW = 32,
    parameter int AW = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [1:0]    cmd_op,
    input  logic [AW-1:0] cmd_a,
    input  logic [AW-1:0] cmd_b,
    input  logic [DW-1:0] cmd_data,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic [DW-1:0] rsp_data1,
    output logic [DW-1:0] rsp_data2,
    output logic          busy,
    output logic [AW-1:0] rb_ra1,
    output logic [AW-1:0] rb_ra2,
    output logic [AW-1:0] rb_wa,
    output logic          rb_write,
    output logic [DW-1:0] rb_wdata,
    input  logic [DW-1:0] rb_rdata1,
    input  logic [DW-1:0] rb_rdata2
);

    localparam int NREG = 2 ** AW;

    localparam logic [1:0] OP_WRITE = 2'b00;
    localparam logic [1:0] OP_READ  = 2'b01;
    localparam logic [1:0] OP_SWAP  = 2'b10;
    localparam logic [1:0] OP_COPY  = 2'b11;

    typedef enum logic [2:0] {
        S_INIT,
        S_IDLE,
        S_RD,
        S_WR1,
        S_WR2,
        S_RESP
    } state_e;

`ifdef REGBANK_INIT_CLEAR_EN
    localparam state_e RST_STATE = S_INIT;
    logic [AW:0] init_cnt_q, init_cnt_d;
`else
    localparam state_e RST_STATE = S_IDLE;
`endif

    state_e        state_q, state_d;
    logic [1:0]    op_q, op_d;
    logic [AW-1:0] a_q, a_d;
    logic [AW-1:0] b_q, b_d;
    logic [DW-1:0] tmp_q, tmp_d;
    logic          cmd_ready_q, cmd_ready_d;
    logic          busy_q, busy_d;
    logic          rsp_valid_q, rsp_valid_d;
    logic [DW-1:0] rsp_data1_q, rsp_data1_d;
    logic [DW-1:0] rsp_data2_q, rsp_data2_d;
    logic [AW-1:0] rb_ra1_q, rb_ra1_d;
    logic [AW-1:0] rb_ra2_q, rb_ra2_d;
    logic [AW-1:0] rb_wa_q, rb_wa_d;
    logic          rb_write_q, rb_write_d;
    logic [DW-1:0] rb_wdata_q, rb_wdata_d;

    // Next state plus next value of every registered output.
    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        a_d         = a_q;
        b_d         = b_q;
        tmp_d       = tmp_q;
        rsp_valid_d = rsp_valid_q;
        rsp_data1_d = rsp_data1_q;
        rsp_data2_d = rsp_data2_q;
        rb_ra1_d    = rb_ra1_q;
        rb_ra2_d    = rb_ra2_q;
        rb_wa_d     = rb_wa_q;
        rb_write_d  = 1'b0;
        rb_wdata_d  = rb_wdata_q;
`ifdef REGBANK_INIT_CLEAR_EN
        init_cnt_d  = init_cnt_q;
`endif
        unique case (state_q)
            S_INIT: begin
`ifdef REGBANK_INIT_CLEAR_EN
                if (init_cnt_q == (AW+1)'(NREG)) begin
                    state_d = S_IDLE;
                end else begin
                    rb_write_d = 1'b1;
                    rb_wa_d    = init_cnt_q[AW-1:0];
                    rb_wdata_d = '0;
                    init_cnt_d = init_cnt_q + 1'b1;
                end
`else
                state_d = S_IDLE;
`endif
            end
            S_IDLE: begin
                if (cmd_valid) begin
                    op_d = cmd_op;
                    a_d  = cmd_a;
                    b_d  = cmd_b;
                    if (cmd_op == OP_WRITE) begin
                        state_d    = S_WR1;
                        rb_write_d = 1'b1;
                        rb_wa_d    = cmd_a;
                        rb_wdata_d = cmd_data;
                    end else begin
                        state_d  = S_RD;
                        rb_ra1_d = cmd_a;
                        rb_ra2_d = cmd_b;
                    end
                end
            end
            S_RD: begin
                if (op_q == OP_READ) begin
                    state_d     = S_RESP;
                    rsp_valid_d = 1'b1;
                    rsp_data1_d = rb_rdata1;
                    rsp_data2_d = rb_rdata2;
                end else if (op_q == OP_SWAP || op_q == OP_COPY) begin
                    state_d    = S_WR1;
                    tmp_d      = rb_rdata1;
                    rb_write_d = 1'b1;
                    rb_wa_d    = a_q;
                    rb_wdata_d = rb_rdata2;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_WR1: begin
                if (op_q == OP_SWAP) begin
                    state_d    = S_WR2;
                    rb_write_d = 1'b1;
                    rb_wa_d    = b_q;
                    rb_wdata_d = tmp_q;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_WR2: state_d = S_IDLE;
            S_RESP: begin
                if (rsp_ready) begin
                    state_d     = S_IDLE;
                    rsp_valid_d = 1'b0;
                end
            end
            default: state_d = S_IDLE;
        endcase
        cmd_ready_d = (state_d == S_IDLE);
        busy_d      = (state_d != S_IDLE);
    end

    // State and registered outputs; reset drops any pending write at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= RST_STATE;
            op_q        <= '0;
            a_q         <= '0;
            b_q         <= '0;
            tmp_q       <= '0;
            cmd_ready_q <= (RST_STATE == S_IDLE);
            busy_q      <= (RST_STATE != S_IDLE);
            rsp_valid_q <= 1'b0;
            rsp_data1_q <= '0;
            rsp_data2_q <= '0;
            rb_ra1_q    <= '0;
            rb_ra2_q    <= '0;
            rb_wa_q     <= '0;
            rb_write_q  <= 1'b0;
            rb_wdata_q  <= '0;
`ifdef REGBANK_INIT_CLEAR_EN
            init_cnt_q  <= '0;
`endif
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            a_q         <= a_d;
            b_q         <= b_d;
            tmp_q       <= tmp_d;
            cmd_ready_q <= cmd_ready_d;
            busy_q      <= busy_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data1_q <= rsp_data1_d;
            rsp_data2_q <= rsp_data2_d;
            rb_ra1_q    <= rb_ra1_d;
            rb_ra2_q    <= rb_ra2_d;
            rb_wa_q     <= rb_wa_d;
            rb_write_q  <= rb_write_d;
            rb_wdata_q  <= rb_wdata_d;
`ifdef REGBANK_INIT_CLEAR_EN
            init_cnt_q  <= init_cnt_d;
`endif
        end
    end

    assign cmd_ready = cmd_ready_q;
    assign busy      = busy_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data1 = rsp_data1_q;
    assign rsp_data2 = rsp_data2_q;
    assign rb_ra1    = rb_ra1_q;
    assign rb_ra2    = rb_ra2_q;
    assign rb_wa     = rb_wa_q;
    assign rb_write  = rb_write_q;
    assign rb_wdata  = rb_wdata_q;

endmodule

// File: tb/tb_regbank_master.sv
// Bench for regbank_master: behavioural bank plus array model of
// register contents; directed steps followed by random commands.
module tb_regbank_master;

    localparam int DW   = 32;
    localparam int AW   = 2;
    localparam int NREG = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [1:0]    cmd_op;
    logic [AW-1:0] cmd_a;
    logic [AW-1:0] cmd_b;
    logic [DW-1:0] cmd_data;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [DW-1:0] rsp_data1;
    logic [DW-1:0] rsp_data2;
    logic          busy;
    logic [AW-1:0] rb_ra1;
    logic [AW-1:0] rb_ra2;
    logic [AW-1:0] rb_wa;
    logic          rb_write;
    logic [DW-1:0] rb_wdata;
    logic [DW-1:0] rb_rdata1;
    logic [DW-1:0] rb_rdata2;

    logic [DW-1:0] bank [NREG];
    logic [DW-1:0] mdl  [NREG];

    int n_checks = 0;
    int n_fail   = 0;

    regbank_master #(.DW(DW), .AW(AW)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_a(cmd_a), .cmd_b(cmd_b),
        .cmd_data(cmd_data),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data1(rsp_data1), .rsp_data2(rsp_data2),
        .busy(busy),
        .rb_ra1(rb_ra1), .rb_ra2(rb_ra2), .rb_wa(rb_wa),
        .rb_write(rb_write), .rb_wdata(rb_wdata),
        .rb_rdata1(rb_rdata1), .rb_rdata2(rb_rdata2)
    );

    always #5 clk = ~clk;

    // Behavioural bank: combinational reads, write at rising edge.
    always_ff @(posedge clk) begin
        if (rb_write) bank[rb_wa] <= rb_wdata;
    end
    assign rb_rdata1 = bank[rb_ra1];
    assign rb_rdata2 = bank[rb_ra2];

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_bank(input string tag);
        for (int i = 0; i < NREG; i++)
            chk($sformatf("%s_reg%0d", tag, i), 64'(bank[i]), 64'(mdl[i]));
    endtask

    // Issue one command and follow it to completion, checking timing,
    // response data and the resulting bank contents against the model.
    task automatic issue(input logic [1:0] op, input int a, input int b,
                         input logic [DW-1:0] d, input int hold);
        int n;
        logic [DW-1:0] e1, e2, t;
        n = 0;
        while (cmd_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("cmd_ready_wait", 64'(cmd_ready), 64'(1));
        e1 = mdl[a];
        e2 = mdl[b];
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_a     = AW'(a);
        cmd_b     = AW'(b);
        cmd_data  = d;
        @(negedge clk);
        cmd_valid = 1'b0;
        case (op)
            2'b00: mdl[a] = d;
            2'b10: begin
                t = mdl[a];
                mdl[a] = mdl[b];
                mdl[b] = t;
            end
            2'b11: mdl[a] = mdl[b];
            default: ;
        endcase
        if (op == 2'b01) begin
            @(negedge clk);
            chk("rsp_valid", 64'(rsp_valid), 64'(1));
            chk("rsp_data1", 64'(rsp_data1), 64'(e1));
            chk("rsp_data2", 64'(rsp_data2), 64'(e2));
            if (hold > 0) begin
                cmd_valid = 1'b1;
                cmd_op    = 2'b00;
                cmd_a     = AW'(a);
                cmd_data  = 32'hDEADBEEF;
            end
            for (int i = 0; i < hold; i++) begin
                @(negedge clk);
                chk("hold_valid", 64'(rsp_valid), 64'(1));
                chk("hold_data1", 64'(rsp_data1), 64'(e1));
                chk("hold_data2", 64'(rsp_data2), 64'(e2));
                chk("hold_ready", 64'(cmd_ready), 64'(0));
            end
            rsp_ready = 1'b1;
            @(negedge clk);
            rsp_ready = 1'b0;
            cmd_valid = 1'b0;
            chk("rsp_done_valid", 64'(rsp_valid), 64'(0));
            chk("rsp_done_ready", 64'(cmd_ready), 64'(1));
        end else begin
            n = 0;
            while (busy === 1'b1 && n < 10) begin
                n++;
                @(negedge clk);
            end
            chk("busy_cycles", 64'(n),
                64'(op == 2'b00 ? 1 : (op == 2'b10 ? 3 : 2)));
            chk("no_rsp", 64'(rsp_valid), 64'(0));
        end
        check_bank("bank");
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #12;
`ifdef REGBANK_INIT_CLEAR_EN
        for (int i = 0; i < NREG; i++) mdl[i] = '0;
`endif
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        cmd_valid = 1'b0;
        cmd_op    = '0;
        cmd_a     = '0;
        cmd_b     = '0;
        cmd_data  = '0;
        rsp_ready = 1'b0;
        for (int i = 0; i < NREG; i++) mdl[i] = '0;
        rst_n = 1'b0;
        #12;
        chk("rst_rb_write", 64'(rb_write), 64'(0));
        chk("rst_rb_wa", 64'(rb_wa), 64'(0));
        chk("rst_rb_ra1", 64'(rb_ra1), 64'(0));
        chk("rst_rb_ra2", 64'(rb_ra2), 64'(0));
        chk("rst_rb_wdata", 64'(rb_wdata), 64'(0));
        chk("rst_rsp_valid", 64'(rsp_valid), 64'(0));
        chk("rst_rsp_data1", 64'(rsp_data1), 64'(0));
        chk("rst_rsp_data2", 64'(rsp_data2), 64'(0));
`ifdef REGBANK_INIT_CLEAR_EN
        chk("rst_busy", 64'(busy), 64'(1));
        chk("rst_cmd_ready", 64'(cmd_ready), 64'(0));
`else
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_cmd_ready", 64'(cmd_ready), 64'(1));
`endif
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < NREG; i++) issue(2'b00, i, 0, 32'h0, 0);
        issue(2'b00, 1, 0, 32'h00145601, 0);
        issue(2'b00, 2, 0, 32'h00000987, 0);
        issue(2'b01, 2, 1, 32'h0, 0);
        chk("t2_data1", 64'(rsp_data1), 64'h00000987);
        chk("t2_data2", 64'(rsp_data2), 64'h00145601);
        issue(2'b10, 1, 2, 32'h0, 0);
        issue(2'b01, 1, 2, 32'h0, 5);
        chk("t3_data1", 64'(rsp_data1), 64'h00000987);
        chk("t3_data2", 64'(rsp_data2), 64'h00145601);
        issue(2'b11, 3, 1, 32'h0, 0);
        issue(2'b01, 3, 1, 32'h0, 0);
        chk("t5_copy1", 64'(rsp_data1), 64'h00000987);
        chk("t5_copy2", 64'(rsp_data2), 64'h00000987);
        issue(2'b10, 2, 2, 32'h0, 0);
        issue(2'b01, 2, 2, 32'h0, 0);
        chk("t5_swap1", 64'(rsp_data1), 64'h00145601);
        chk("t5_swap2", 64'(rsp_data2), 64'h00145601);

        for (int k = 0; k < 80; k++) begin
            issue(2'($urandom_range(0, 3)), int'($urandom_range(0, NREG-1)),
                  int'($urandom_range(0, NREG-1)), $urandom,
                  int'($urandom_range(0, 3)));
        end

        // Reset during the first write of a SWAP: nothing commits.
        chk("pre_swap_ready", 64'(cmd_ready), 64'(1));
        cmd_valid = 1'b1;
        cmd_op    = 2'b10;
        cmd_a     = 2'd0;
        cmd_b     = 2'd3;
        @(negedge clk);
        cmd_valid = 1'b0;
        @(negedge clk);
        chk("swap_wr1_write", 64'(rb_write), 64'(1));
        rst_n = 1'b0;
        #1;
        chk("arst_rb_write", 64'(rb_write), 64'(0));
        chk("arst_rsp_valid", 64'(rsp_valid), 64'(0));
`ifdef REGBANK_INIT_CLEAR_EN
        chk("arst_busy", 64'(busy), 64'(1));
`else
        chk("arst_busy", 64'(busy), 64'(0));
`endif
        do_reset();
        issue(2'b01, 0, 3, 32'h0, 0);
        issue(2'b10, 0, 3, 32'h0, 1);
        issue(2'b01, 3, 0, 32'h0, 2);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
